pow2_rr_sched: RTL and testbench
================================

# pow2_rr_sched

Round-robin scheduler that shares one `pow2` unit between `num_clients_p` requesters. Each client presents an exponent with a valid/ready handshake. The scheduler grants one client per issue cycle, forwards its exponent to the shared `pow2`, and records the client ID in an in-order tag FIFO. It then steers each `pow2` result back to the client that issued it, using a valid/yumi handshake. It sits between the client-side request logic and the single `pow2` instance.

## Interface
- `num_clients_p`, 4, number of requesters (≥2).
- `width_p`, 32, exponent and result width.
- `max_out_p`, 4, maximum requests in flight inside `pow2`; sets the tag FIFO depth (power of 2).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `cl_v_i`  in  `num_clients_p`  per-client request valid.
- `cl_exp_i`  in  `num_clients_p*width_p`  packed exponents; client i occupies bits `[i*width_p +: width_p]`.
- `cl_ready_o`  out  `num_clients_p`  per-client request accepted this cycle.
- `cl_data_o`  out  `width_p`  result data, broadcast to all clients.
- `cl_v_o`  out  `num_clients_p`  per-client result valid; one-hot or zero.
- `cl_yumi_i`  in  `num_clients_p`  per-client result consume.
- `pow2_exp_o`  out  `width_p`  exponent to `pow2`.
- `pow2_v_o`  out  1  request valid to `pow2`.
- `pow2_ready_i`  in  1  `pow2` can accept.
- `pow2_data_i`  in  `width_p`  `pow2` result.
- `pow2_v_i`  in  1  `pow2` result valid.
- `pow2_yumi_o`  out  1  result consumed.
- `outstanding_o`  out  `$clog2(max_out_p)+1`  number of requests in flight.
- `error_o`  out  1  sticky: `pow2_v_i` was seen while no request was in flight.

## Operation
- **Arbitration.** Round-robin with priority pointer `ptr_r`. The grant goes to the first i with `cl_v_i[i]`=1, searching i = `ptr_r`, `ptr_r`+1, … modulo `num_clients_p`.
- **Grant inputs.** The grant depends only on `cl_v_i`, `ptr_r` and FIFO-full. It never depends on `pow2_ready_i`, so there is no valid/ready combinational loop.
- **Issue request.** `pow2_v_o` = (any `cl_v_i`) & ~fifo_full. `pow2_exp_o` = the granted client's exponent; it is 0 when there is no grant.
- **Client ready.** `cl_ready_o[g]` = `pow2_v_o` & `pow2_ready_i` for the granted client g. All other bits are 0.
- **Issue event.** An issue occurs when `pow2_v_o` & `pow2_ready_i`. On an issue:
  - g is pushed into the tag FIFO.
  - `ptr_r` becomes (g+1) mod `num_clients_p`.
  - Without an issue, `ptr_r` holds.
- **Return routing.** With head tag h and fifo_nonempty:
  - `cl_v_o[h]` = `pow2_v_i` & fifo_nonempty; all other `cl_v_o` bits are 0.
  - `cl_data_o` = `pow2_data_i`.
  - `pow2_yumi_o` = `cl_v_o[h]` & `cl_yumi_i[h]`.
  - `cl_yumi_i` bits for non-valid clients are ignored.
- **Pop.** `pow2_yumi_o` pops the tag FIFO.
- **Same-cycle push and pop.** Both are allowed in one cycle. `outstanding_o` is unchanged when they coincide.
- **Full FIFO.** When the FIFO is full (`outstanding_o` == `max_out_p`), no issue occurs, even if a pop happens in the same cycle.
- **Error.** `pow2_v_i` while the FIFO is empty sets `error_o` (sticky until reset). In that case `pow2_yumi_o` stays 0.
- **Reset values** (`reset_n_i`=0, immediate):
  - `ptr_r`=0, FIFO empty, `outstanding_o`=0, `error_o`=0.
  - As a consequence, `pow2_v_o`, `cl_ready_o` and `cl_v_o` are gated only by the inputs and an empty FIFO.
- **Reset mid-operation.** All in-flight tags are dropped. `pow2` must share the same reset so that no orphan result returns afterwards.

## Timing
- **Issue path.** Combinational, zero added latency: the request reaches `pow2` in the cycle it is granted. Tag push and pointer update take effect at the rising edge.
- **Return path.** Combinational: result, valid and yumi pass through in the same cycle. The pop takes effect at the edge.
- **Ordering.** `pow2` must return results in issue order, with ≥1 cycle latency. Under that condition the tag is always written before its result appears.
- **Fairness.** A continuously requesting client is granted within `num_clients_p` issue events.
- **Throughput.** With `pow2` ready every cycle and yumi asserted every cycle, one issue per cycle is sustained indefinitely.
- **Release.** Reset release is asynchronous to the clock. Stimulus may begin on the first rising edge after `reset_n_i` goes high.

## Test plan
- **Single client.** Client 2 requests exp=5; `pow2` ready, returns 1 cycle later.
  - Expect `cl_ready_o`=4'b0100, `pow2_exp_o`=5.
  - Then `cl_v_o`=4'b0100, `cl_data_o`=32.
  - After `cl_yumi_i[2]`, `outstanding_o` returns to 0.
- **Round-robin.** All 4 clients hold exp=i, `pow2` always ready.
  - Grant order 0,1,2,3,0.
  - Results 1,2,4,8 routed to `cl_v_o` bits 0,1,2,3 in that order.
- **Backpressure.** `pow2_ready_i`=0 for 3 cycles with clients 1 and 3 valid.
  - `cl_ready_o`=0 and `ptr_r` holds throughout.
  - On release, client 1 is granted first.
- **Full FIFO.** `max_out_p`=4, `pow2` withholds results, 5 requests pending.
  - After 4 issues, `outstanding_o`=4 and `pow2_v_o`=0.
  - A yumi in cycle N permits an issue no earlier than cycle N+1.
- **Result stall.** `cl_yumi_i`=0 for 2 cycles while `pow2_v_i`=1.
  - `pow2_yumi_o`=0 and the FIFO is unchanged.
  - Yumi on the third cycle pops exactly one tag.
- **Error and reset.**
  - `pow2_v_i`=1 with the FIFO empty: `error_o`=1 on the next edge and stays 1.
  - Asserting `reset_n_i` low with 3 outstanding immediately clears `error_o` and `outstanding_o` to 0.

Source files
------------

// File: rtl/pow2_rr_sched.sv
// Round-robin scheduler sharing one pow2 unit among several clients.
// Results return in order and are routed to their owners through an in-order tag FIFO.
module pow2_rr_sched #(
    parameter int unsigned num_clients_p = 4,
    parameter int unsigned width_p       = 32,
    parameter int unsigned max_out_p     = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_clients_p-1:0]           cl_v_i,
    input  logic [num_clients_p*width_p-1:0]   cl_exp_i,
    output logic [num_clients_p-1:0]           cl_ready_o,
    output logic [width_p-1:0]                 cl_data_o,
    output logic [num_clients_p-1:0]           cl_v_o,
    input  logic [num_clients_p-1:0]           cl_yumi_i,
    output logic [width_p-1:0]                 pow2_exp_o,
    output logic                               pow2_v_o,
    input  logic                               pow2_ready_i,
    input  logic [width_p-1:0]                 pow2_data_i,
    input  logic                               pow2_v_i,
    output logic                               pow2_yumi_o,
    output logic [$clog2(max_out_p):0]         outstanding_o,
    output logic                               error_o
);
    localparam int unsigned id_w   = $clog2(num_clients_p);
    localparam int unsigned addr_w = (max_out_p > 1) ? $clog2(max_out_p) : 1;
    localparam int unsigned cnt_w  = $clog2(max_out_p) + 1;

    logic [id_w-1:0]   ptr_r;
    logic [id_w-1:0]   grant_id;
    logic              grant_v;
    logic [id_w-1:0]   head_id;
    logic              fifo_full;
    logic              fifo_nonempty;
    logic              issue;
    logic              pop;
    logic [id_w-1:0]   tag_mem [max_out_p];
    logic [addr_w-1:0] wr_ptr_r;
    logic [addr_w-1:0] rd_ptr_r;
    logic [cnt_w-1:0]  count_r;
    logic              error_r;

    function automatic logic [id_w-1:0] rr_idx(input logic [id_w-1:0] base, input int unsigned off);
        return id_w'((32'(base) + off) % num_clients_p);
    endfunction

    function automatic logic [addr_w-1:0] adv(input logic [addr_w-1:0] a);
        return (a == addr_w'(max_out_p - 1)) ? '0 : a + addr_w'(1);
    endfunction

    // First requesting client at or after the priority pointer
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        for (int unsigned k = 0; k < num_clients_p; k++) begin
            if (!grant_v && cl_v_i[rr_idx(ptr_r, k)]) begin
                grant_v  = 1'b1;
                grant_id = rr_idx(ptr_r, k);
            end
        end
    end

    assign fifo_full     = (count_r == cnt_w'(max_out_p));
    assign fifo_nonempty = (count_r != '0);
    assign pow2_v_o      = grant_v & ~fifo_full;
    assign issue         = pow2_v_o & pow2_ready_i;
    assign head_id       = tag_mem[rd_ptr_r];
    assign cl_data_o     = pow2_data_i;
    assign pow2_yumi_o   = pow2_v_i & fifo_nonempty & cl_yumi_i[head_id];
    assign pop           = pow2_yumi_o;
    assign outstanding_o = count_r;
    assign error_o       = error_r;

    always_comb begin
        pow2_exp_o = '0;
        if (grant_v) begin
            pow2_exp_o = cl_exp_i[32'(grant_id) * width_p +: width_p];
        end
    end

    // One-hot accept to the granted client, one-hot result valid to the head-tag owner
    always_comb begin
        cl_ready_o = '0;
        cl_v_o     = '0;
        for (int unsigned i = 0; i < num_clients_p; i++) begin
            cl_ready_o[i] = issue && (grant_id == id_w'(i));
            cl_v_o[i]     = pow2_v_i && fifo_nonempty && (head_id == id_w'(i));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            error_r  <= 1'b0;
            for (int unsigned i = 0; i < max_out_p; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (issue) begin
                tag_mem[wr_ptr_r] <= grant_id;
                wr_ptr_r          <= adv(wr_ptr_r);
                ptr_r             <= (grant_id == id_w'(num_clients_p - 1)) ? '0 : grant_id + id_w'(1);
            end
            if (pop) begin
                rd_ptr_r <= adv(rd_ptr_r);
            end
            case ({issue, pop})
                2'b10:   count_r <= count_r + cnt_w'(1);
                2'b01:   count_r <= count_r - cnt_w'(1);
                default: count_r <= count_r;
            endcase
            // A result with nothing in flight is unattributable
            if (pow2_v_i && !fifo_nonempty) begin
                error_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pow2_rr_sched.sv
// Bench for pow2_rr_sched: pow2 stub, directed phases plus random traffic, scoreboard monitor.
module tb_pow2_rr_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = $clog2(MO) + 1;

    logic           clk_i = 1'b0;
    logic           reset_n_i = 1'b0;
    logic [N-1:0]   cl_v_i = '0;
    logic [N*W-1:0] cl_exp_i = '0;
    logic [N-1:0]   cl_ready_o;
    logic [W-1:0]   cl_data_o;
    logic [N-1:0]   cl_v_o;
    logic [N-1:0]   cl_yumi_i = '0;
    logic [W-1:0]   pow2_exp_o;
    logic           pow2_v_o;
    logic           pow2_ready_i = 1'b0;
    logic [W-1:0]   pow2_data_i = '0;
    logic           pow2_v_i = 1'b0;
    logic           pow2_yumi_o;
    logic [CW-1:0]  outstanding_o;
    logic           error_o;

    pow2_rr_sched #(.num_clients_p(N), .width_p(W), .max_out_p(MO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cl_v_i(cl_v_i), .cl_exp_i(cl_exp_i), .cl_ready_o(cl_ready_o),
        .cl_data_o(cl_data_o), .cl_v_o(cl_v_o), .cl_yumi_i(cl_yumi_i),
        .pow2_exp_o(pow2_exp_o), .pow2_v_o(pow2_v_o), .pow2_ready_i(pow2_ready_i),
        .pow2_data_i(pow2_data_i), .pow2_v_i(pow2_v_i), .pow2_yumi_o(pow2_yumi_o),
        .outstanding_o(outstanding_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned  client;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] stub_q[$];
    int           total = 0;
    int           bad = 0;
    logic         ret_en = 1'b0;
    logic         bogus = 1'b0;
    logic         sv_issue = 1'b0;
    logic         sv_pop = 1'b0;
    logic [W-1:0] sv_exp = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // pow2 stub: in-order, one-cycle minimum latency, result held until consumed
    always @(negedge clk_i) begin
        sv_issue = reset_n_i && pow2_v_o && pow2_ready_i;
        sv_exp   = pow2_exp_o;
        sv_pop   = reset_n_i && pow2_yumi_o;
    end

    always @(posedge clk_i) begin
        #2;
        if (!reset_n_i) begin
            stub_q.delete();
        end else begin
            if (sv_pop && stub_q.size() > 0) void'(stub_q.pop_front());
            if (sv_issue) stub_q.push_back(sv_exp);
        end
        sv_issue = 1'b0;
        sv_pop   = 1'b0;
        pow2_v_i    = bogus || (ret_en && stub_q.size() > 0);
        pow2_data_i = (stub_q.size() > 0) ? (W'(1) << stub_q[0]) : '0;
    end

    // Reference model state: priority pointer, in-flight count, sticky error
    int unsigned  m_ptr = 0;
    int unsigned  m_cnt = 0;
    logic         m_err = 1'b0;
    int unsigned  m_g;
    logic         m_found;
    logic         e_issue;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_clv;
    logic         e_yumi;
    logic [W-1:0] e_exp;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            m_ptr = 0;
            m_cnt = 0;
            m_err = 1'b0;
            exp_q.delete();
            chk("rst_outstanding", 64'(outstanding_o), 64'd0);
            chk("rst_error", 64'(error_o), 64'd0);
            chk("rst_cl_v", 64'(cl_v_o), 64'd0);
        end else begin
            chk("outstanding", 64'(outstanding_o), 64'(m_cnt));
            chk("error", 64'(error_o), 64'(m_err));
            m_found = 1'b0;
            m_g = 0;
            for (int k = 0; k < N; k++) begin
                if (!m_found && cl_v_i[(m_ptr + k) % N]) begin
                    m_found = 1'b1;
                    m_g = (m_ptr + k) % N;
                end
            end
            e_issue = m_found && (m_cnt < MO) && pow2_ready_i;
            e_ready = e_issue ? (N'(1) << m_g) : '0;
            e_exp   = m_found ? cl_exp_i[m_g*W +: W] : '0;
            chk("pow2_v", 64'(pow2_v_o), 64'(m_found && (m_cnt < MO)));
            chk("cl_ready", 64'(cl_ready_o), 64'(e_ready));
            chk("pow2_exp", 64'(pow2_exp_o), 64'(e_exp));
            chk("cl_data_pass", 64'(cl_data_o), 64'(pow2_data_i));
            e_clv  = '0;
            e_yumi = 1'b0;
            if (pow2_v_i && m_cnt > 0 && exp_q.size() > 0) begin
                e_clv  = N'(1) << exp_q[0].client;
                e_yumi = cl_yumi_i[exp_q[0].client];
                chk("result_data", 64'(cl_data_o), 64'(exp_q[0].data));
            end
            chk("cl_v", 64'(cl_v_o), 64'(e_clv));
            chk("pow2_yumi", 64'(pow2_yumi_o), 64'(e_yumi));
            if (pow2_v_i && m_cnt == 0) m_err = 1'b1;
            if (e_yumi) begin
                void'(exp_q.pop_front());
                m_cnt--;
            end
            if (e_issue) begin
                exp_q.push_back('{client: m_g, data: (W'(1) << e_exp)});
                m_cnt++;
                m_ptr = (m_g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_exp(input int unsigned i, input int unsigned e);
        cl_exp_i[i*W +: W] = W'(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        reset_n_i = 1'b1;
        step();

        // Round-robin: every client requests exp=i
        for (int i = 0; i < N; i++) set_exp(i, i);
        cl_v_i = '1; pow2_ready_i = 1'b1; ret_en = 1'b1; cl_yumi_i = '1;
        repeat (5) step();
        cl_v_i = '0;
        repeat (4) step();

        // Single client 2 with exp=5
        set_exp(2, 5);
        cl_v_i = 4'b0100;
        step();
        cl_v_i = '0;
        repeat (3) step();

        // Backpressure with clients 1 and 3, pointer parked at 1
        cl_v_i = 4'b0001;
        step();
        cl_v_i = 4'b1010; pow2_ready_i = 1'b0;
        repeat (3) step();
        pow2_ready_i = 1'b1;
        step();
        cl_v_i = '0;
        repeat (4) step();

        // Full FIFO: results withheld, then released while requests persist
        ret_en = 1'b0; cl_v_i = '1;
        repeat (6) step();
        ret_en = 1'b1;
        repeat (8) step();
        cl_v_i = '0;
        repeat (6) step();

        // Result stall: yumi withheld two cycles
        ret_en = 1'b0; cl_v_i = 4'b0011;
        repeat (2) step();
        cl_v_i = '0; cl_yumi_i = '0; ret_en = 1'b1;
        repeat (2) step();
        cl_yumi_i = '1;
        repeat (4) step();

        // Spurious result with nothing in flight
        bogus = 1'b1;
        step();
        bogus = 1'b0;
        repeat (3) step();

        // Reset with three requests in flight
        ret_en = 1'b0; cl_v_i = '1;
        repeat (3) step();
        cl_v_i = '0;
        step();
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("async_rst_error", 64'(error_o), 64'd0);
        repeat (2) step();
        reset_n_i = 1'b1;
        step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            cl_v_i       = N'($urandom);
            for (int i = 0; i < N; i++) set_exp(i, $urandom_range(0, 31));
            pow2_ready_i = ($urandom_range(0, 3) != 0);
            ret_en       = ($urandom_range(0, 3) != 0);
            cl_yumi_i    = N'($urandom);
            step();
        end

        cl_v_i = '0; ret_en = 1'b1; cl_yumi_i = '1; pow2_ready_i = 1'b1;
        repeat (12) step();
        chk("drain_outstanding", 64'(outstanding_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
